// File: rtl/axi_rr_arbiter.sv
// rtl/axi_rr_arbiter.sv - round-robin sharing of one AXI4 master port between IFU read, LSU read and LSU write
module axi_rr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [ID_W-1:0]     m0_arid,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [1:0]          m0_arburst,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic [ID_W-1:0]     m0_rid,
    output logic                m0_rlast,

    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [ID_W-1:0]     m1_arid,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [1:0]          m1_arburst,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic [ID_W-1:0]     m1_rid,
    output logic                m1_rlast,

    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [ID_W-1:0]     m1_awid,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic [1:0]          m1_awburst,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [1:0]          m1_bresp,
    output logic [ID_W-1:0]     m1_bid,

    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [ID_W-1:0]     s_arid,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic [ID_W-1:0]     s_rid,
    input  logic                s_rlast,

    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [ID_W-1:0]     s_awid,
    output logic [7:0]          s_awlen,
    output logic [2:0]          s_awsize,
    output logic [1:0]          s_awburst,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [1:0]          s_bresp,
    input  logic [ID_W-1:0]     s_bid,

    output logic                busy,
    output logic [1:0]          grant
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_AR,
        ST_RD_R,
        ST_WR_AW,
        ST_WR_W,
        ST_WR_B
    } state_t;

    state_t     r_state;
    logic [1:0] r_last;
    logic [1:0] r_sel;
    logic [1:0] r_grant;
    logic       r_busy;

    logic [2:0] w_req;
    logic       w_any;
    logic [1:0] w_win;
    logic       w_sel_m1;

    assign w_req    = {m1_awvalid, m1_arvalid, m0_arvalid};
    assign w_any    = |w_req;
    assign w_sel_m1 = (r_sel == 2'd1);
    assign busy     = r_busy;
    assign grant    = r_grant;

    // Search begins one past the previous winner, wrapping modulo 3.
    always_comb begin
        w_win = 2'd0;
        case (r_last)
            2'd0: begin
                if (w_req[1])      w_win = 2'd1;
                else if (w_req[2]) w_win = 2'd2;
                else               w_win = 2'd0;
            end
            2'd1: begin
                if (w_req[2])      w_win = 2'd2;
                else if (w_req[0]) w_win = 2'd0;
                else               w_win = 2'd1;
            end
            default: begin
                if (w_req[0])      w_win = 2'd0;
                else if (w_req[1]) w_win = 2'd1;
                else               w_win = 2'd2;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_last  <= 2'd2;
            r_sel   <= 2'd0;
            r_grant <= 2'd3;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_last  <= w_win;
                        r_sel   <= w_win;
                        r_grant <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= (w_win == 2'd2) ? ST_WR_AW : ST_RD_AR;
                    end
                end
                ST_RD_AR: begin
                    if (s_arready) r_state <= ST_RD_R;
                end
                ST_RD_R: begin
                    if (s_rvalid && s_rready && s_rlast) begin
                        r_state <= ST_IDLE;
                        r_grant <= 2'd3;
                        r_busy  <= 1'b0;
                    end
                end
                ST_WR_AW: begin
                    if (s_awready) r_state <= ST_WR_W;
                end
                ST_WR_W: begin
                    if (m1_wvalid && s_wready && m1_wlast) r_state <= ST_WR_B;
                end
                ST_WR_B: begin
                    if (s_bvalid && m1_bready) begin
                        r_state <= ST_IDLE;
                        r_grant <= 2'd3;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 2'd3;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Channels are only connected in their owning state; everything else reads as zero.
    always_comb begin
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = '0;
        m0_rid     = '0;
        m0_rlast   = 1'b0;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = '0;
        m1_rid     = '0;
        m1_rlast   = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        m1_bresp   = '0;
        m1_bid     = '0;
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_arid     = '0;
        s_arlen    = '0;
        s_arsize   = '0;
        s_arburst  = '0;
        s_rready   = 1'b0;
        s_awvalid  = 1'b0;
        s_awaddr   = '0;
        s_awid     = '0;
        s_awlen    = '0;
        s_awsize   = '0;
        s_awburst  = '0;
        s_wvalid   = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wlast    = 1'b0;
        s_bready   = 1'b0;
        case (r_state)
            ST_RD_AR: begin
                s_arvalid  = 1'b1;
                s_araddr   = w_sel_m1 ? m1_araddr  : m0_araddr;
                s_arid     = w_sel_m1 ? m1_arid    : m0_arid;
                s_arlen    = w_sel_m1 ? m1_arlen   : m0_arlen;
                s_arsize   = w_sel_m1 ? m1_arsize  : m0_arsize;
                s_arburst  = w_sel_m1 ? m1_arburst : m0_arburst;
                m0_arready = !w_sel_m1 && s_arready;
                m1_arready =  w_sel_m1 && s_arready;
            end
            ST_RD_R: begin
                s_rready = w_sel_m1 ? m1_rready : m0_rready;
                if (w_sel_m1) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rid    = s_rid;
                    m1_rlast  = s_rlast;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rid    = s_rid;
                    m0_rlast  = s_rlast;
                end
            end
            ST_WR_AW: begin
                s_awvalid  = 1'b1;
                s_awaddr   = m1_awaddr;
                s_awid     = m1_awid;
                s_awlen    = m1_awlen;
                s_awsize   = m1_awsize;
                s_awburst  = m1_awburst;
                m1_awready = s_awready;
            end
            ST_WR_W: begin
                s_wvalid  = m1_wvalid;
                s_wdata   = m1_wdata;
                s_wstrb   = m1_wstrb;
                s_wlast   = m1_wlast;
                m1_wready = s_wready;
            end
            ST_WR_B: begin
                m1_bvalid = s_bvalid;
                m1_bresp  = s_bresp;
                m1_bid    = s_bid;
                s_bready  = m1_bready;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb/tb_axi_rr_arbiter.sv - directed vector table plus multi-cycle sequences for axi_rr_arbiter
module tb_axi_rr_arbiter;

    logic        clock = 1'b0;
    logic        reset;

    logic        m0_arvalid, m0_arready;
    logic [31:0] m0_araddr;
    logic [3:0]  m0_arid;
    logic [7:0]  m0_arlen;
    logic [2:0]  m0_arsize;
    logic [1:0]  m0_arburst;
    logic        m0_rvalid, m0_rready;
    logic [31:0] m0_rdata;
    logic [1:0]  m0_rresp;
    logic [3:0]  m0_rid;
    logic        m0_rlast;

    logic        m1_arvalid, m1_arready;
    logic [31:0] m1_araddr;
    logic [3:0]  m1_arid;
    logic [7:0]  m1_arlen;
    logic [2:0]  m1_arsize;
    logic [1:0]  m1_arburst;
    logic        m1_rvalid, m1_rready;
    logic [31:0] m1_rdata;
    logic [1:0]  m1_rresp;
    logic [3:0]  m1_rid;
    logic        m1_rlast;

    logic        m1_awvalid, m1_awready;
    logic [31:0] m1_awaddr;
    logic [3:0]  m1_awid;
    logic [7:0]  m1_awlen;
    logic [2:0]  m1_awsize;
    logic [1:0]  m1_awburst;
    logic        m1_wvalid, m1_wready;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_wlast;
    logic        m1_bvalid, m1_bready;
    logic [1:0]  m1_bresp;
    logic [3:0]  m1_bid;

    logic        s_arvalid, s_arready;
    logic [31:0] s_araddr;
    logic [3:0]  s_arid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_rvalid, s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic [3:0]  s_rid;
    logic        s_rlast;

    logic        s_awvalid, s_awready;
    logic [31:0] s_awaddr;
    logic [3:0]  s_awid;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        s_wvalid, s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;
    logic [3:0]  s_bid;

    logic        busy;
    logic [1:0]  grant;

    axi_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clock(clock), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m0_rid(m0_rid), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_rid(m1_rid), .m1_rlast(m1_rlast),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
        .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_wlast(m1_wlast),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp), .m1_bid(m1_bid),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rid(s_rid), .s_rlast(s_rlast),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
        .busy(busy), .grant(grant)
    );

    always #5 clock = ~clock;

    // in : {m1_awvalid,m1_arvalid,m0_arvalid, s_arready,s_rvalid,s_rlast, m1_rready,m0_rready,
    //       s_awready,m1_wvalid,m1_wlast,s_wready, s_bvalid,m1_bready}
    // exp: {grant[1:0], busy, s_arvalid, m1_arready,m0_arready, m1_rvalid,m0_rvalid, s_rready,
    //       s_awvalid,m1_wready,s_wvalid, m1_bvalid,s_bready}
    typedef struct {
        string       name;
        logic [13:0] in;
        logic [13:0] exp;
    } vec_t;

    localparam logic [13:0] IDLE_CTL = 14'b11_0_0_00_00_0_000_00;
    localparam logic [13:0] M0_AR    = 14'b00_1_1_01_00_0_000_00;
    localparam logic [13:0] M0_R     = 14'b00_1_0_00_01_1_000_00;
    localparam logic [13:0] M1_AR    = 14'b01_1_1_10_00_0_000_00;
    localparam logic [13:0] M1_R     = 14'b01_1_0_00_10_1_000_00;
    localparam logic [13:0] WR_AWC   = 14'b10_1_0_00_00_0_100_00;
    localparam logic [13:0] WR_WWAIT = 14'b10_1_0_00_00_0_001_00;
    localparam logic [13:0] WR_WGO   = 14'b10_1_0_00_00_0_011_00;
    localparam logic [13:0] WR_BC    = 14'b10_1_0_00_00_0_000_11;

    vec_t        vecs[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          ng;
    int          beat;
    logic [1:0]  got[4];
    logic [1:0]  exp3[4];
    logic [1:0]  prev;
    logic        gap, done, hs, m0_seen;

    function automatic vec_t mk(input string n, input logic [13:0] i, input logic [13:0] e);
        vec_t v;
        v.name = n;
        v.in   = i;
        v.exp  = e;
        return v;
    endfunction

    function automatic logic [13:0] ctl();
        return {grant, busy, s_arvalid, m1_arready, m0_arready, m1_rvalid, m0_rvalid, s_rready,
                s_awvalid, m1_wready, s_wvalid, m1_bvalid, s_bready};
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
        end
    endtask

    task automatic apply_in(input logic [13:0] v);
        {m1_awvalid, m1_arvalid, m0_arvalid, s_arready, s_rvalid, s_rlast, m1_rready, m0_rready,
         s_awready, m1_wvalid, m1_wlast, s_wready, s_bvalid, m1_bready} = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply_in(14'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        m0_araddr = 32'h3000_0000; m0_arid = 4'h1; m0_arlen = 8'd0; m0_arsize = 3'd2; m0_arburst = 2'd1;
        m1_araddr = 32'h4000_0004; m1_arid = 4'h2; m1_arlen = 8'd0; m1_arsize = 3'd2; m1_arburst = 2'd1;
        m1_awaddr = 32'h8000_0010; m1_awid = 4'h3; m1_awlen = 8'd0; m1_awsize = 3'd2; m1_awburst = 2'd1;
        m1_wdata  = 32'h1234_5678; m1_wstrb = 4'hF;
        s_rdata = 32'hDEAD_BEEF; s_rresp = 2'd0; s_rid = 4'h0;
        s_bresp = 2'd0; s_bid = 4'h5;

        vecs.push_back(mk("m0rd_idle",  14'b001_100_11_0000_00, IDLE_CTL));
        vecs.push_back(mk("m0rd_ar",    14'b001_100_11_0000_00, M0_AR));
        vecs.push_back(mk("m0rd_r",     14'b000_111_11_0000_00, M0_R));
        vecs.push_back(mk("m0rd_done",  14'b000_000_11_0000_00, IDLE_CTL));
        for (int k = 0; k < 2; k++) begin
            vecs.push_back(mk($sformatf("cont%0d_idle1", k), 14'b011_111_11_0000_00, IDLE_CTL));
            vecs.push_back(mk($sformatf("cont%0d_ar1",   k), 14'b011_111_11_0000_00, M1_AR));
            vecs.push_back(mk($sformatf("cont%0d_r1",    k), 14'b011_111_11_0000_00, M1_R));
            vecs.push_back(mk($sformatf("cont%0d_idle0", k), 14'b011_111_11_0000_00, IDLE_CTL));
            vecs.push_back(mk($sformatf("cont%0d_ar0",   k), 14'b011_111_11_0000_00, M0_AR));
            vecs.push_back(mk($sformatf("cont%0d_r0",    k), 14'b011_111_11_0000_00, M0_R));
        end
        vecs.push_back(mk("cont_done",  14'b000_000_11_0000_00, IDLE_CTL));
        vecs.push_back(mk("wr_idle",    14'b100_000_11_0111_01, IDLE_CTL));
        vecs.push_back(mk("wr_aw_wait1",14'b100_000_11_0111_01, WR_AWC));
        vecs.push_back(mk("wr_aw_wait2",14'b100_000_11_0111_01, WR_AWC));
        vecs.push_back(mk("wr_aw_wait3",14'b100_000_11_0111_01, WR_AWC));
        vecs.push_back(mk("wr_aw_hs",   14'b100_000_11_1111_01, WR_AWC));
        vecs.push_back(mk("wr_w_wait1", 14'b000_000_11_0110_01, WR_WWAIT));
        vecs.push_back(mk("wr_w_wait2", 14'b000_000_11_0110_01, WR_WWAIT));
        vecs.push_back(mk("wr_w_hs",    14'b000_000_11_0111_01, WR_WGO));
        vecs.push_back(mk("wr_b",       14'b000_000_11_0000_11, WR_BC));
        vecs.push_back(mk("wr_done",    14'b000_000_11_0000_01, IDLE_CTL));

        reset = 1'b1;
        apply_in(14'd0);
        @(negedge clock);
        chk("reset_state", ctl(), IDLE_CTL);
        @(posedge clock);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            apply_in(vecs[i].in);
            @(negedge clock);
            chk(vecs[i].name, ctl(), vecs[i].exp);
            if (vecs[i].exp[10])
                chk({vecs[i].name, "_araddr"}, s_araddr,
                    (vecs[i].exp[13:12] == 2'd0) ? 32'h3000_0000 : 32'h4000_0004);
            else
                chk({vecs[i].name, "_araddr_zero"}, s_araddr, 32'h0);
            if (vecs[i].exp[7])
                chk({vecs[i].name, "_m1_rdata"}, m1_rdata, 32'hDEAD_BEEF);
            if (vecs[i].exp[6])
                chk({vecs[i].name, "_m0_rdata"}, m0_rdata, 32'hDEAD_BEEF);
            if (vecs[i].exp[4])
                chk({vecs[i].name, "_aw"}, {s_awaddr, s_awid}, {32'h8000_0010, 4'h3});
            if (vecs[i].exp[2])
                chk({vecs[i].name, "_w"}, {s_wdata, s_wstrb, s_wlast}, {32'h1234_5678, 4'hF, 1'b1});
            if (vecs[i].exp[1])
                chk({vecs[i].name, "_b"}, {m1_bresp, m1_bid}, {2'd0, 4'h5});
            @(posedge clock);
            #1;
        end

        // Three-way contention from reset: expect 0,1,2 then 0 again.
        exp3[0] = 2'd0; exp3[1] = 2'd1; exp3[2] = 2'd2; exp3[3] = 2'd0;
        reset = 1'b1;
        apply_in(14'b111_111_11_1111_11);
        @(negedge clock);
        chk("rst_hold_outputs", ctl(), IDLE_CTL);
        chk("rst_hold_araddr", s_araddr, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        ng = 0;
        prev = 2'd3;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(negedge clock);
            if (prev == 2'd3 && grant != 2'd3) begin
                got[ng] = grant;
                ng++;
            end
            prev = grant;
            @(posedge clock);
            #1;
        end
        chk("3way_count", ng, 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("3way_grant%0d", k), got[k], exp3[k]);

        // M1 read burst of 4 beats with gapped rvalid and toggling rready.
        do_reset();
        m1_arlen = 8'd3;
        m1_arvalid = 1'b1;
        s_arready = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("burst_ar", {grant, s_arvalid, s_arlen}, {2'd1, 1'b1, 8'd3});
        @(posedge clock);
        #1;
        m1_arvalid = 1'b0;
        s_arready = 1'b0;
        beat = 0; gap = 1'b0; done = 1'b0; m0_seen = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (!s_rvalid) begin
                if (gap) begin
                    s_rvalid = 1'b1;
                    s_rdata  = 32'hA0 + 32'(beat);
                    s_rlast  = (beat == 3);
                end
                gap = !gap;
            end
            m1_rready = c[0];
            @(negedge clock);
            hs = m1_rvalid && m1_rready;
            if (m0_rvalid) m0_seen = 1'b1;
            if (hs) begin
                chk($sformatf("burst_beat%0d_data", beat), {m1_rdata, m1_rlast},
                    {32'hA0 + 32'(beat), beat == 3});
            end
            @(posedge clock);
            #1;
            if (hs) begin
                s_rvalid = 1'b0;
                if (s_rlast) begin
                    done = 1'b1;
                    chk("burst_exit", {grant, busy}, {2'd3, 1'b0});
                end else begin
                    chk($sformatf("burst_stay%0d", beat), {grant, busy}, {2'd1, 1'b1});
                end
                beat++;
            end
        end
        chk("burst_beats", beat, 4);
        chk("burst_m0_quiet", m0_seen, 1'b0);
        s_rlast = 1'b0;
        m1_rready = 1'b0;
        m1_arlen = 8'd0;

        // Reset while beat 2 of a 4-beat M0 burst is on the bus.
        m0_arlen = 8'd3;
        m0_arvalid = 1'b1;
        s_arready = 1'b1;
        m0_rready = 1'b1;
        m1_rready = 1'b1;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        m0_arvalid = 1'b0;
        s_arready = 1'b0;
        s_rvalid = 1'b1;
        s_rlast = 1'b0;
        s_rdata = 32'hB0;
        @(posedge clock);
        #1 s_rdata = 32'hB1;
        @(posedge clock);
        #1 s_rdata = 32'hB2;
        @(negedge clock);
        chk("rstmid_beat2", {m0_rvalid, m0_rdata}, {1'b1, 32'hB2});
        #1 reset = 1'b1;
        #1 chk("rstmid_now", ctl(), IDLE_CTL);
        @(posedge clock);
        #1 chk("rstmid_next", ctl(), IDLE_CTL);
        chk("rstmid_m0_rdata", m0_rdata, 32'h0);
        reset = 1'b0;
        m0_arlen = 8'd0;
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        s_arready = 1'b1;
        s_rlast = 1'b1;
        s_rdata = 32'hC0;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("post_first_grant", grant, 2'd0);
        @(posedge clock);
        #1 m0_arvalid = 1'b0;
        @(negedge clock);
        chk("post_m0_r", {m0_rvalid, m0_rdata}, {1'b1, 32'hC0});
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("post_m1_ar", {grant, s_araddr}, {2'd1, 32'h4000_0004});
        @(posedge clock);
        #1 m1_arvalid = 1'b0;
        @(negedge clock);
        chk("post_m1_r", {m1_rvalid, m1_rdata}, {1'b1, 32'hC0});
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("post_idle", {grant, busy}, {2'd3, 1'b0});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
